// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stage-enable and hazard FSM for the 5-stage RV32IM pipeline
module pipeline_sequencer #(
    parameter int MRET_DRAIN_CYCLES = 3,
    parameter int COUNT_W           = 32
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               INST_VALID,
    input  logic               CONDITIONAL_JUMP,
    input  logic               MRET,
    input  logic [4:0]         DEC_RS1,
    input  logic [4:0]         DEC_RS2,
    input  logic [4:0]         EX_RD,
    input  logic               EX_IS_LOAD,
    input  logic               BR_RESOLVED,
    input  logic               BR_TAKEN,
    input  logic               MD_START,
    input  logic               MD_DONE,
    output logic               FETCH_ENABLED,
    output logic               DECODER_ENABLED,
    output logic               EXEC_ENABLED,
    output logic               MEM_ENABLED,
    output logic               WB_ENABLED,
    output logic               BUBBLE,
    output logic               FLUSH,
    output logic [2:0]         STATE,
    output logic [COUNT_W-1:0] STALL_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN        = 3'd1,
        S_LOAD_STALL = 3'd2,
        S_BR_WAIT    = 3'd3,
        S_MD_BUSY    = 3'd4,
        S_MRET_DRAIN = 3'd5,
        S_FLUSH      = 3'd6
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(MRET_DRAIN_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] drain;
    logic [3:0] drain_nxt;
    logic       load_use;
    logic [6:0] outs;

    assign load_use = INST_VALID & EX_IS_LOAD & (EX_RD != 5'd0) &
                      ((EX_RD == DEC_RS1) | (EX_RD == DEC_RS2));

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= S_IDLE;
            drain <= 4'd0;
        end else begin
            state <= state_nxt;
            drain <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        drain_nxt = drain;
        case (state)
            S_IDLE:       state_nxt = INST_VALID ? S_RUN : S_IDLE;
            S_RUN: begin
                // Priority order: mul/div, load-use, mret, branch
                if (MD_START)                            state_nxt = S_MD_BUSY;
                else if (load_use)                       state_nxt = S_LOAD_STALL;
                else if (INST_VALID && MRET) begin
                    state_nxt = S_MRET_DRAIN;
                    drain_nxt = DRAIN_INIT;
                end
                else if (INST_VALID && CONDITIONAL_JUMP) state_nxt = S_BR_WAIT;
                else                                     state_nxt = S_RUN;
            end
            S_LOAD_STALL: state_nxt = S_RUN;
            S_BR_WAIT: begin
                if (BR_RESOLVED) state_nxt = BR_TAKEN ? S_FLUSH : S_RUN;
                else             state_nxt = S_BR_WAIT;
            end
            S_MD_BUSY:    state_nxt = MD_DONE ? S_RUN : S_MD_BUSY;
            S_MRET_DRAIN: begin
                if (drain == 4'd0) begin
                    state_nxt = S_FLUSH;
                end else begin
                    state_nxt = S_MRET_DRAIN;
                    drain_nxt = drain - 4'd1;
                end
            end
            S_FLUSH:      state_nxt = S_RUN;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Moore decode, bit order F D E M W BUBBLE FLUSH
    always_comb begin
        outs = 7'b0000000;
        case (state)
            S_RUN:        outs = 7'b1111100;
            S_LOAD_STALL: outs = 7'b0011110;
            S_BR_WAIT:    outs = 7'b0011100;
            S_MD_BUSY:    outs = 7'b0001100;
            S_MRET_DRAIN: outs = 7'b0011100;
            S_FLUSH:      outs = 7'b1001101;
            default:      outs = 7'b0000000;
        endcase
    end

    assign {FETCH_ENABLED, DECODER_ENABLED, EXEC_ENABLED, MEM_ENABLED,
            WB_ENABLED, BUBBLE, FLUSH} = outs;
    assign STATE = state;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            STALL_COUNT <= '0;
        end else if (state != S_IDLE && state != S_RUN && STALL_COUNT != '1) begin
            STALL_COUNT <= STALL_COUNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - scoreboard bench for pipeline_sequencer
module tb_pipeline_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        inst_valid, conditional_jump, mret;
    logic [4:0]  dec_rs1, dec_rs2, ex_rd;
    logic        ex_is_load, br_resolved, br_taken, md_start, md_done;

    logic        f_en, d_en, e_en, m_en, w_en, bubble, flush;
    logic [2:0]  state;
    logic [31:0] stall_count;
    logic        f_en2, d_en2, e_en2, m_en2, w_en2, bubble2, flush2;
    logic [2:0]  state2;
    logic [1:0]  stall_count2;

    always #5 clk = ~clk;

    pipeline_sequencer #(.MRET_DRAIN_CYCLES(3), .COUNT_W(32)) dut (
        .CLK(clk), .RSTN(rstn), .INST_VALID(inst_valid),
        .CONDITIONAL_JUMP(conditional_jump), .MRET(mret),
        .DEC_RS1(dec_rs1), .DEC_RS2(dec_rs2), .EX_RD(ex_rd),
        .EX_IS_LOAD(ex_is_load), .BR_RESOLVED(br_resolved), .BR_TAKEN(br_taken),
        .MD_START(md_start), .MD_DONE(md_done),
        .FETCH_ENABLED(f_en), .DECODER_ENABLED(d_en), .EXEC_ENABLED(e_en),
        .MEM_ENABLED(m_en), .WB_ENABLED(w_en), .BUBBLE(bubble), .FLUSH(flush),
        .STATE(state), .STALL_COUNT(stall_count)
    );

    pipeline_sequencer #(.MRET_DRAIN_CYCLES(3), .COUNT_W(2)) dut_sat (
        .CLK(clk), .RSTN(rstn), .INST_VALID(inst_valid),
        .CONDITIONAL_JUMP(conditional_jump), .MRET(mret),
        .DEC_RS1(dec_rs1), .DEC_RS2(dec_rs2), .EX_RD(ex_rd),
        .EX_IS_LOAD(ex_is_load), .BR_RESOLVED(br_resolved), .BR_TAKEN(br_taken),
        .MD_START(md_start), .MD_DONE(md_done),
        .FETCH_ENABLED(f_en2), .DECODER_ENABLED(d_en2), .EXEC_ENABLED(e_en2),
        .MEM_ENABLED(m_en2), .WB_ENABLED(w_en2), .BUBBLE(bubble2), .FLUSH(flush2),
        .STATE(state2), .STALL_COUNT(stall_count2)
    );

    typedef struct {
        logic [2:0]  st;
        logic [31:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [2:0]  prev_st  = 3'd0;
    logic [31:0] exp_cnt  = 0;

    function automatic logic [6:0] outs_of(input logic [2:0] s);
        case (s)
            3'd1:    return 7'b1111100;
            3'd2:    return 7'b0011110;
            3'd3:    return 7'b0011100;
            3'd4:    return 7'b0001100;
            3'd5:    return 7'b0011100;
            3'd6:    return 7'b1001101;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply current inputs across one rising edge; expectation is queued after the edge
    task automatic step(input logic [2:0] es);
        exp_t e;
        @(posedge clk);
        #1;
        if (!rstn) exp_cnt = 0;
        else if (prev_st != 3'd0 && prev_st != 3'd1) exp_cnt = exp_cnt + 1;
        prev_st = es;
        e.st   = es;
        e.cnt  = exp_cnt;
        e.cnt2 = (exp_cnt > 3) ? 2'd3 : exp_cnt[1:0];
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        conditional_jump = 0; mret = 0; dec_rs1 = 0; dec_rs2 = 0; ex_rd = 0;
        ex_is_load = 0; br_resolved = 0; br_taken = 0; md_start = 0; md_done = 0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("state", 32'(state), 32'(e.st));
            check("outs", 32'({f_en, d_en, e_en, m_en, w_en, bubble, flush}), 32'(outs_of(e.st)));
            check("stall_count", stall_count, e.cnt);
            check("state_sat", 32'(state2), 32'(e.st));
            check("stall_count_sat", 32'(stall_count2), 32'(e.cnt2));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 0; inst_valid = 1; clear_inputs();
        step(3'd0); step(3'd0);
        rstn = 1; inst_valid = 0;
        step(3'd0);
        inst_valid = 1;
        step(3'd1);

        // load-use on rs2, then on rs1
        ex_is_load = 1; ex_rd = 5; dec_rs2 = 5;
        step(3'd2);
        clear_inputs(); step(3'd1);
        ex_is_load = 1; ex_rd = 7; dec_rs1 = 7;
        step(3'd2);
        clear_inputs(); step(3'd1);
        // rd=x0 never stalls; invalid instruction never stalls
        ex_is_load = 1; ex_rd = 0; dec_rs1 = 0; dec_rs2 = 0;
        step(3'd1);
        ex_rd = 5; dec_rs2 = 5; inst_valid = 0;
        step(3'd1);
        clear_inputs(); inst_valid = 1;

        // taken branch
        conditional_jump = 1; step(3'd3);
        conditional_jump = 0; step(3'd3);
        br_resolved = 1; br_taken = 1; step(3'd6);
        clear_inputs(); step(3'd1);

        // not-taken branch
        conditional_jump = 1; step(3'd3);
        conditional_jump = 0; step(3'd3);
        br_resolved = 1; br_taken = 0; step(3'd1);
        clear_inputs(); step(3'd1);

        // priority: mul/div beats load-use and branch
        md_start = 1; ex_is_load = 1; ex_rd = 3; dec_rs1 = 3; conditional_jump = 1;
        step(3'd4);
        clear_inputs();
        for (int i = 0; i < 4; i++) step(3'd4);
        md_done = 1; step(3'd1);
        step(3'd1);
        clear_inputs();

        // single-cycle mul/div
        md_start = 1; step(3'd4);
        md_start = 0; md_done = 1; step(3'd1);
        clear_inputs();

        // mret drain
        mret = 1; step(3'd5);
        mret = 0; step(3'd5); step(3'd5);
        step(3'd6);
        step(3'd1);

        // reset during second BR_WAIT cycle
        conditional_jump = 1; step(3'd3);
        conditional_jump = 0; step(3'd3);
        rstn = 0; step(3'd0);
        rstn = 1; step(3'd1);

        @(negedge clk); #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
